ws2812_multi: RTL and testbench
===============================

// Module: ws2812_multi
// PURPOSE
//  Multi-channel WS2812/SK6812 LED-string driver for the SoC LED peripheral.
//  Holds one pixel buffer per channel and sends a frame on every channel in lockstep when triggered.
//  Supports 24-bit RGB and 32-bit RGBW pixels, with bit timing derived from CLK_MHZ.
//  Sits behind the bus register block: writes go into the pixel RAM, and a start pulse sends the frame.
// PARAMETERS
//  NUM_CHAN     4    independent output strings (1..8)
//  NUM_LEDS     64   pixels per channel (2..256)
//  BITS_PER_LED 24   24 = GRB, 32 = GRBW; sent MSB first
//  CLK_MHZ      96   clk frequency in MHz
//  T1H_NS       900  high time of a '1' bit
//  T0H_NS       350  high time of a '0' bit
//  TBIT_NS      1250 full bit period
//  TLATCH_US    280  low time after a frame (latch/reset)
//  Cycle counts are ceil(CLK_MHZ*X_NS/1000), or CLK_MHZ*TLATCH_US for the latch time.
// PORTS
//  clk        in   1                   system clock
//  reset_n    in   1                   asynchronous, active-low reset
//  wr_en      in   1                   pixel write strobe, one pixel per cycle
//  wr_chan    in   max(1,clog2(NUM_CHAN))  target channel
//  wr_led     in   clog2(NUM_LEDS)     target pixel index
//  wr_data    in   BITS_PER_LED        pixel value
//  start      in   1                   frame request pulse
//  busy       out  1                   high from start acceptance until frame_done
//  frame_done out  1                   1-cycle pulse at the end of the latch period
//  data_out   out  NUM_CHAN            serial output, one bit per string
// BEHAVIOUR
//  Reset: state=IDLE; all counters 0; data_out, busy and frame_done all 0.
//   Pixel RAM is NOT cleared (it is inferred as BRAM).
//  Reset asserted mid-frame: outputs drop to 0 asynchronously; the next frame starts clean.
//  Writes: RAM[wr_chan][wr_led] <= wr_data, 1 cycle, accepted in any state.
//   A write with wr_chan>=NUM_CHAN or wr_led>=NUM_LEDS is ignored.
//  FSM:
//   IDLE:  start=1 -> LOAD; busy<=1. In IDLE data_out=0.
//   LOAD:  1 cycle; issue RAM read of pixel 0, all channels in parallel -> DATA.
//   DATA:  bit_cnt runs 0..T_BIT-1. Per channel, data_out[c] = (bit_cnt < (pix[c][b] ? T1H : T0H)).
//          Index b runs BITS_PER_LED-1..0.
//          Next pixel is prefetched one cycle before its first bit, so there are no gaps between pixels.
//          After bit 0 of pixel NUM_LEDS-1 -> LATCH.
//   LATCH: data_out=0 for T_LATCH cycles -> IDLE. On the exit cycle frame_done=1 and busy<=0.
//  start is ignored when not in IDLE. start and frame_done in the same cycle is ignored, so start must be re-pulsed.
//  Pixel order is index 0 first; index 0 is the pixel nearest the connector.
//  A write to a pixel not yet fetched in the current frame appears in that frame.
//  Frame length: 1 + NUM_LEDS*BITS_PER_LED*T_BIT + T_LATCH cycles, start to frame_done.
//  data_out is registered, so there is 1 cycle of latency from bit_cnt to the pin.
// CONFIGURATION
//  WS2812_DBUF_EN defined:
//   - pixel RAM is two banks per channel;
//   - writes always go to the back bank and the frame reads the front bank;
//   - banks swap on the cycle start is accepted;
//   - writes during a frame never affect the frame in flight;
//   - the new back bank holds the frame before last (no copy).
//  WS2812_DBUF_EN undefined: one bank, write-through behaviour as described above.
// TESTING
//  Defaults for all tests: T_BIT=120, T1H=87, T0H=34, T_LATCH=26880.
//  1. NUM_LEDS=2, ch0 pix0=0x800000, start:
//     - ch0 first bit high 87 cycles, low 33;
//     - the next 47 bits are high 34, low 86;
//     - all other channels carry only '0' bits.
//  2. Full frame:
//     - frame_done arrives exactly 1+64*24*120+26880 cycles after start;
//     - busy is high throughout.
//  3. start pulsed mid-frame and on the frame_done cycle:
//     - both are ignored;
//     - a later start in IDLE starts a frame 1 cycle later (LOAD).
//  4. Out-of-range writes:
//     - wr_chan=NUM_CHAN is ignored, so the frame is unchanged;
//     - wr_led=NUM_LEDS-1 on ch3 appears only on data_out[3].
//  5. reset_n=0 at half-frame:
//     - data_out, busy and frame_done are 0 the same cycle;
//     - after release, start gives a full correct frame.
//  6. WS2812_DBUF_EN, write pix5=0xFFFFFF during a frame:
//     - the current frame sends the old value;
//     - the next start sends 0xFFFFFF.

Source files
------------

// File: rtl/ws2812_multi.sv
// Multi-channel WS2812/SK6812 driver: per-channel pixel RAM, all strings sent in lockstep.
// Optional WS2812_DBUF_EN: two RAM banks per channel, swapped when a frame starts.
module ws2812_multi #(
    parameter int NUM_CHAN     = 4,
    parameter int NUM_LEDS     = 64,
    parameter int BITS_PER_LED = 24,
    parameter int CLK_MHZ      = 96,
    parameter int T1H_NS       = 900,
    parameter int T0H_NS       = 350,
    parameter int TBIT_NS      = 1250,
    parameter int TLATCH_US    = 280
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    input  logic                                            wr_en,
    input  logic [((NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1)-1:0] wr_chan,
    input  logic [$clog2(NUM_LEDS)-1:0]                      wr_led,
    input  logic [BITS_PER_LED-1:0]                          wr_data,
    input  logic                                            start,
    output logic                                            busy,
    output logic                                            frame_done,
    output logic [NUM_CHAN-1:0]                              data_out
);

    localparam int T_BIT   = (CLK_MHZ * TBIT_NS + 999) / 1000;
    localparam int T1H     = (CLK_MHZ * T1H_NS + 999) / 1000;
    localparam int T0H     = (CLK_MHZ * T0H_NS + 999) / 1000;
    localparam int T_LATCH = CLK_MHZ * TLATCH_US;

    localparam int CW  = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int LW  = $clog2(NUM_LEDS);
    localparam int BCW = $clog2(T_BIT);
    localparam int LCW = $clog2(T_LATCH);
    localparam int BIW = $clog2(BITS_PER_LED);
`ifdef WS2812_DBUF_EN
    localparam int AW  = LW + 1;
`else
    localparam int AW  = LW;
`endif

    localparam logic [BCW-1:0] BIT_LAST  = BCW'(T_BIT - 1);
    localparam logic [BCW-1:0] T1H_C     = BCW'(T1H);
    localparam logic [BCW-1:0] T0H_C     = BCW'(T0H);
    localparam logic [LCW-1:0] LATCH_PRE = LCW'(T_LATCH - 2);
    localparam logic [LCW-1:0] LATCH_END = LCW'(T_LATCH - 1);
    localparam logic [LW-1:0]  LED_LAST  = LW'(NUM_LEDS - 1);
    localparam logic [BIW-1:0] BIT_TOP   = BIW'(BITS_PER_LED - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DATA, LATCH} state_t;

    state_t                  state;
    logic [BCW-1:0]          bit_cnt;
    logic [BIW-1:0]          bit_idx;
    logic [LW-1:0]           led_cnt;
    logic [LCW-1:0]          latch_cnt;

    logic [BITS_PER_LED-1:0] mem  [NUM_CHAN][1 << AW];
    logic [BITS_PER_LED-1:0] rd_q [NUM_CHAN];
    logic                    rd_en;
    logic [LW-1:0]           rd_led;
    logic                    wr_ok;
    logic [AW-1:0]           waddr;
    logic [AW-1:0]           raddr;
`ifdef WS2812_DBUF_EN
    logic                    front;
`endif

    always_comb begin
        wr_ok  = wr_en && ((CW+1)'(wr_chan) < (CW+1)'(NUM_CHAN))
                       && ((LW+1)'(wr_led) < (LW+1)'(NUM_LEDS));
        // The next pixel is fetched on the last cycle of the current one, so bits run gap-free.
        rd_en  = (state == LOAD) ||
                 (state == DATA && bit_cnt == BIT_LAST && bit_idx == '0 && led_cnt != LED_LAST);
        rd_led = (state == LOAD) ? '0 : led_cnt + 1'b1;
`ifdef WS2812_DBUF_EN
        waddr  = {~front, wr_led};
        raddr  = {front, rd_led};
`else
        waddr  = wr_led;
        raddr  = rd_led;
`endif
    end

    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < NUM_CHAN; c++) begin
            if (wr_ok && wr_chan == CW'(c))
                mem[c][waddr] <= wr_data;
            if (rd_en)
                rd_q[c] <= mem[c][raddr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            led_cnt    <= '0;
            latch_cnt  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            data_out   <= '0;
`ifdef WS2812_DBUF_EN
            front      <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    data_out <= '0;
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
`ifdef WS2812_DBUF_EN
                        front <= ~front;
`endif
                    end
                end
                LOAD: begin
                    data_out <= '0;
                    bit_cnt  <= '0;
                    bit_idx  <= BIT_TOP;
                    led_cnt  <= '0;
                    state    <= DATA;
                end
                DATA: begin
                    for (int unsigned c = 0; c < NUM_CHAN; c++)
                        data_out[c] <= (bit_cnt < (rd_q[c][bit_idx] ? T1H_C : T0H_C));
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (bit_idx == '0) begin
                            bit_idx <= BIT_TOP;
                            if (led_cnt == LED_LAST) begin
                                state     <= LATCH;
                                latch_cnt <= '0;
                            end else begin
                                led_cnt <= led_cnt + 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx - 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                LATCH: begin
                    data_out  <= '0;
                    latch_cnt <= latch_cnt + 1'b1;
                    if (latch_cnt == LATCH_PRE)
                        frame_done <= 1'b1;
                    if (latch_cnt == LATCH_END) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_multi.sv
// Directed self-checking bench for ws2812_multi (5 channels, 2 LEDs, shortened latch).
// Frames are decoded from data_out and compared against a pixel-bank model.
module tb_ws2812_multi;

    localparam int NUM_CHAN  = 5;
    localparam int NUM_LEDS  = 2;
    localparam int BITS      = 24;
    localparam int TB_BIT    = 120;
    localparam int TB_1H     = 87;
    localparam int TB_0H     = 34;
    localparam int TB_LATCH  = 960;
    localparam int NBT       = NUM_LEDS * BITS * TB_BIT;
    localparam int FRAME_LEN = 1 + NBT + TB_LATCH;
`ifdef WS2812_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                wr_en = 1'b0;
    logic [2:0]          wr_chan = '0;
    logic [0:0]          wr_led = '0;
    logic [23:0]         wr_data = '0;
    logic                start = 1'b0;
    logic                busy;
    logic                frame_done;
    logic [NUM_CHAN-1:0] data_out;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [23:0] bk [2][NUM_CHAN][NUM_LEDS];
    int bfront = 0;

    ws2812_multi #(
        .NUM_CHAN(NUM_CHAN), .NUM_LEDS(NUM_LEDS), .BITS_PER_LED(BITS), .CLK_MHZ(96),
        .T1H_NS(900), .T0H_NS(350), .TBIT_NS(1250), .TLATCH_US(10)
    ) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_chan(wr_chan), .wr_led(wr_led),
        .wr_data(wr_data), .start(start), .busy(busy), .frame_done(frame_done),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int wb();
        return DBUF ? 1 - bfront : 0;
    endfunction

    function automatic int rb();
        return DBUF ? bfront : 0;
    endfunction

    function automatic void model_write(input int ch, input int led, input logic [23:0] d);
        if (ch < NUM_CHAN && led < NUM_LEDS)
            bk[wb()][ch][led] = d;
    endfunction

    task automatic write_pix(input int ch, input int led, input logic [23:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_chan = 3'(ch); wr_led = 1'(led); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        model_write(ch, led, d);
    endtask

    task automatic load_pattern(input logic [23:0] base, input logic [23:0] cstep,
                                input logic [23:0] lstep);
        for (int c = 0; c < NUM_CHAN; c++)
            for (int l = 0; l < NUM_LEDS; l++)
                write_pix(c, l, base + 24'(c) * cstep + 24'(l) * lstep);
    endtask

    // act: 0 none, 1 start pulse at data cycle act_cyc, 2 pixel write at data cycle act_cyc
    task automatic run_frame(input string name, input int act, input int act_cyc,
                             input int act_ch, input int act_led, input logic [23:0] act_d,
                             input bit start_on_done);
        logic [119:0] w [NUM_CHAN];
        logic [119:0] ideal;
        logic [23:0]  got [NUM_CHAN][NUM_LEDS];
        bit           bad [NUM_CHAN][NUM_LEDS];
        int busy_bad, lat_bad, done_at, hi, i;
        busy_bad = 0; lat_bad = 0; done_at = -1; i = 0;
        for (int c = 0; c < NUM_CHAN; c++)
            for (int l = 0; l < NUM_LEDS; l++) begin
                got[c][l] = '0; bad[c][l] = 1'b0;
            end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        if (DBUF) bfront = 1 - bfront;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL %s busy_on_start: got %b want 1", name, busy);
        else pass_cnt++;
        @(negedge clk);
        for (int l = 0; l < NUM_LEDS; l++)
            for (int b = BITS - 1; b >= 0; b--) begin
                for (int c = 0; c < NUM_CHAN; c++) w[c] = '0;
                for (int k = 0; k < TB_BIT; k++) begin
                    @(negedge clk);
                    if (busy !== 1'b1) busy_bad++;
                    if (act == 1 && i == act_cyc) start = 1'b1;
                    if (act == 1 && i == act_cyc + 1) start = 1'b0;
                    if (act == 2 && i == act_cyc) begin
                        wr_en = 1'b1; wr_chan = 3'(act_ch); wr_led = 1'(act_led); wr_data = act_d;
                    end
                    if (act == 2 && i == act_cyc + 1) begin
                        wr_en = 1'b0;
                        model_write(act_ch, act_led, act_d);
                    end
                    for (int c = 0; c < NUM_CHAN; c++) w[c][k] = (data_out[c] === 1'b1);
                    i++;
                end
                for (int c = 0; c < NUM_CHAN; c++) begin
                    hi = $countones(w[c]);
                    ideal = (120'(1) << hi) - 120'(1);
                    if (w[c] !== ideal || (hi != TB_1H && hi != TB_0H)) bad[c][l] = 1'b1;
                    got[c][l][b] = (hi == TB_1H);
                end
            end
        for (int n = 3 + NBT; n <= FRAME_LEN + 20; n++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_bad++;
            if (data_out !== '0) lat_bad++;
            if (frame_done === 1'b1) begin
                done_at = n;
                if (start_on_done) start = 1'b1;
                break;
            end
        end
        @(negedge clk); start = 1'b0;
        total_cnt++;
        if (done_at != FRAME_LEN)
            $display("FAIL %s frame_len: got %0d want %0d", name, done_at, FRAME_LEN);
        else pass_cnt++;
        total_cnt++;
        if (busy_bad != 0 || lat_bad != 0)
            $display("FAIL %s busy_latch: busy low %0d, latch nonzero %0d, want 0/0", name, busy_bad, lat_bad);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0 || frame_done !== 1'b0)
            $display("FAIL %s idle_after_done: busy %b done %b want 0 0", name, busy, frame_done);
        else pass_cnt++;
        for (int c = 0; c < NUM_CHAN; c++)
            for (int l = 0; l < NUM_LEDS; l++) begin
                total_cnt++;
                if (got[c][l] !== bk[rb()][c][l] || bad[c][l])
                    $display("FAIL %s ch%0d pix%0d: got %h (waveform bad=%0d) want %h",
                             name, c, l, got[c][l], bad[c][l], bk[rb()][c][l]);
                else pass_cnt++;
            end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total_cnt++;
        if (data_out !== '0 || busy !== 1'b0 || frame_done !== 1'b0)
            $display("FAIL reset_hold: data %b busy %b done %b want 0", data_out, busy, frame_done);
        else pass_cnt++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (data_out !== '0 || busy !== 1'b0 || frame_done !== 1'b0)
            $display("FAIL reset_release: data %b busy %b done %b want 0", data_out, busy, frame_done);
        else pass_cnt++;
    endtask

    task automatic test_single_bit();
        load_pattern(24'h000000, 24'h000000, 24'h000000);
        write_pix(0, 0, 24'h800000);
        run_frame("single_bit", 0, 0, 0, 0, 24'h0, 1'b0);
    endtask

    task automatic test_full_frame();
        load_pattern(24'h13579B, 24'h2468AC, 24'h0F0F0F);
        run_frame("full_frame", 0, 0, 0, 0, 24'h0, 1'b0);
    endtask

    task automatic test_start_ignored();
        load_pattern(24'hC0FFEE, 24'h111111, 24'h00F00F);
        run_frame("start_mid", 1, 3000, 0, 0, 24'h0, 1'b1);
        run_frame("start_idle", 0, 0, 0, 0, 24'h0, 1'b0);
    endtask

    task automatic test_out_of_range();
        load_pattern(24'hA5A5A5, 24'h010101, 24'h101010);
        write_pix(5, 0, 24'hABCDEF);
        write_pix(7, 1, 24'h5A5A5A);
        write_pix(3, 1, 24'h123456);
        run_frame("range", 0, 0, 0, 0, 24'h0, 1'b0);
    endtask

    task automatic test_reset_mid();
        load_pattern(24'h00FF00, 24'h000000, 24'h000000);
        write_pix(0, 1, 24'hFFFFFF);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2 + NBT / 2 + 10) @(negedge clk);
        total_cnt++;
        if (data_out[0] !== 1'b1 || busy !== 1'b1)
            $display("FAIL half_frame_active: data0 %b busy %b want 1 1", data_out[0], busy);
        else pass_cnt++;
        #2 reset_n = 1'b0;
        #1;
        total_cnt++;
        if (data_out !== '0 || busy !== 1'b0 || frame_done !== 1'b0)
            $display("FAIL reset_async: data %b busy %b done %b want 0", data_out, busy, frame_done);
        else pass_cnt++;
        bfront = 0;
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(negedge clk);
        load_pattern(24'h3C3C3C, 24'h0A0B0C, 24'h808080);
        run_frame("after_reset", 0, 0, 0, 0, 24'h0, 1'b0);
    endtask

    task automatic test_write_in_flight();
        load_pattern(24'h000F00, 24'h000001, 24'h000100);
        run_frame("wr_flight", 2, 100, 2, 1, 24'hFFFFFF, 1'b0);
        run_frame("wr_next", 0, 0, 0, 0, 24'h0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < NUM_CHAN; c++)
                for (int l = 0; l < NUM_LEDS; l++)
                    bk[k][c][l] = '0;
        test_reset();
        test_single_bit();
        test_full_frame();
        test_start_ignored();
        test_out_of_range();
        test_reset_mid();
        test_write_in_flight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
